bf_weight_loader: RTL



---
 rtl/bf_weight_loader_if.sv | 21 ++
 rtl/bf_weight_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/bf_weight_loader_if.sv
// Single-weight write handshake into the beamformer weight loader.
// The master drives a request; the loader answers with wr_ready.
interface bf_weight_loader_if #(
  parameter int WW = 5
);
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic          wr_bcast;
  logic [WW-1:0] wr_data;

  modport master (
    output wr_valid, wr_addr, wr_bcast, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_bcast, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/bf_weight_loader.sv
// Shadow/active weight banks for the 8-channel beamformer; the shadow bank is
// copied to the active bank atomically on the first update strobe after a commit.
module bf_weight_loader #(
  parameter int NCH = 8,
  parameter int WW  = 5,
  parameter logic signed [WW-1:0] RESET_COS = 5'sd15,
  parameter logic signed [WW-1:0] RESET_SIN = 5'sd0
) (
  input  logic                    clock,
  input  logic                    reset,
  bf_weight_loader_if.slave       wr,
  input  logic                    commit_req,
  input  logic                    update_en,
  output logic                    commit_pending,
  output logic                    commit_done,
  input  logic [4:0]              rd_addr,
  input  logic                    rd_sel,
  output logic [WW-1:0]           rd_data,
  output logic [NCH-1:0][WW-1:0]  w_cos_1,
  output logic [NCH-1:0][WW-1:0]  w_sin_1,
  output logic [NCH-1:0][WW-1:0]  w_cos_2,
  output logic [NCH-1:0][WW-1:0]  w_sin_2
);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  typedef logic [NCH-1:0][WW-1:0] row_t;
  typedef logic [3:0][NCH-1:0][WW-1:0] bank_t;

  // Set index 0..3 = cos1, sin1, cos2, sin2 (packed high-to-low below).
  localparam row_t  COS_ROW    = {NCH{RESET_COS}};
  localparam row_t  SIN_ROW    = {NCH{RESET_SIN}};
  localparam bank_t RESET_BANK = {SIN_ROW, COS_ROW, SIN_ROW, COS_ROW};

  state_t     state;
  state_t     state_next;
  bank_t      shadow;
  bank_t      active;
  logic       commit_fire;
  logic       wr_accept;
  logic [1:0] wr_set;
  logic [2:0] wr_ch;
  logic [1:0] rd_set;
  logic [2:0] rd_ch;

  assign wr_set = wr.wr_addr[4:3];
  assign wr_ch  = wr.wr_addr[2:0];
  assign rd_set = rd_addr[4:3];
  assign rd_ch  = rd_addr[2:0];

  always_comb begin
    state_next  = state;
    commit_fire = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req) state_next = PEND;
      end
      PEND: begin
        if (update_en) begin
          state_next  = IDLE;
          commit_fire = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit_pending = (state == PEND);
  assign wr.wr_ready    = ~commit_pending;
  assign wr_accept      = wr.wr_valid & wr.wr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      commit_done <= 1'b0;
    end else begin
      state       <= state_next;
      commit_done <= commit_fire;
    end
  end

  // Writes are blocked in PEND, so a shadow write never races the copy edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= RESET_BANK;
      active <= RESET_BANK;
    end else begin
      if (wr_accept) begin
        if (wr.wr_bcast) shadow[wr_set]        <= {NCH{wr.wr_data}};
        else             shadow[wr_set][wr_ch] <= wr.wr_data;
      end
      if (commit_fire) active <= shadow;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_sel ? active[rd_set][rd_ch] : shadow[rd_set][rd_ch];
  end

  assign w_cos_1 = active[0];
  assign w_sin_1 = active[1];
  assign w_cos_2 = active[2];
  assign w_sin_2 = active[3];

endmodule
